// File: rtl/cpu_control.sv
// cpu_control: multicycle control unit and ALU sequencer for a 16 x DATA_W
// register file with two asynchronous read ports and one synchronous write
// port. Each instruction passes through IDLE -> DECODE -> EXECUTE ->
// WRITEBACK. That gives one ALU instruction every four cycles.
//
// Handshake: an instruction is taken on a rising edge where instr_valid and
// instr_ready are both high. instr_ready is high only in IDLE. instr and
// instr_valid are don't-care whenever instr_ready is low.
//
// dbg_state exposes the FSM state encoding for observation:
// 0 IDLE, 1 DECODE, 2 EXECUTE, 3 WRITEBACK, 4 HALTED.
module cpu_control #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic [3:0]        rf_addr_r1,
    output logic [3:0]        rf_addr_r2,
    input  logic [DATA_W-1:0] rf_data1,
    input  logic [DATA_W-1:0] rf_data2,
    output logic [3:0]        rf_addr_w,
    output logic              rf_we,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              flag_zero,
    output logic              flag_carry,
    output logic              illegal,
    output logic              halted,
    output logic [CNT_W-1:0]  retired,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_WRITEBACK = 3'd3,
        S_HALTED    = 3'd4
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_LDI  = 4'h5;
    localparam logic [3:0] OP_MOV  = 4'h6;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t             state_q, state_d;
    logic [15:0]        instr_q, instr_d;
    logic [3:0]         raddr1_q, raddr1_d;
    logic [3:0]         raddr2_q, raddr2_d;
    logic [3:0]         waddr_q, waddr_d;
    logic [DATA_W-1:0]  result_q, result_d;
    logic               zero_q, zero_d;
    logic               carry_q, carry_d;
    logic               illegal_q, illegal_d;
    logic [CNT_W-1:0]   retired_q, retired_d;

    logic               accept;
    logic               retire;
    logic [3:0]         op;
    logic [3:0]         dst;
    logic [DATA_W:0]    sum;
    logic [DATA_W-1:0]  diff;
    logic               borrow;

    assign op  = instr_q[15:12];
    assign dst = instr_q[11:8];

    // FSM next state and the state-decoded control outputs.
    always_comb begin
        state_d     = state_q;
        instr_ready = 1'b0;
        rf_we       = 1'b0;
        halted      = 1'b0;
        accept      = 1'b0;
        retire      = 1'b0;
        case (state_q)
            S_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    accept  = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (op)
                    OP_HALT: begin
                        retire  = 1'b1;
                        state_d = S_HALTED;
                    end
                    OP_NOP: begin
                        retire  = 1'b1;
                        state_d = S_IDLE;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_LDI, OP_MOV: begin
                        state_d = S_EXECUTE;
                    end
                    default: begin
                        // Undefined opcode: drop it without a write or a retire.
                        state_d = S_IDLE;
                    end
                endcase
            end
            S_EXECUTE: begin
                state_d = S_WRITEBACK;
            end
            S_WRITEBACK: begin
                rf_we   = 1'b1;
                retire  = 1'b1;
                state_d = S_IDLE;
            end
            S_HALTED: begin
                halted = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Raw ALU terms. Carry comes from the extra sum bit. Borrow is an
    // unsigned compare.
    always_comb begin
        sum    = {1'b0, rf_data1} + {1'b0, rf_data2};
        diff   = rf_data1 - rf_data2;
        borrow = (rf_data1 < rf_data2);
    end

    // Datapath next state: latch on accept, compute in EXECUTE, count retires.
    always_comb begin
        instr_d   = instr_q;
        raddr1_d  = raddr1_q;
        raddr2_d  = raddr2_q;
        waddr_d   = waddr_q;
        result_d  = result_q;
        zero_d    = zero_q;
        carry_d   = carry_q;
        illegal_d = illegal_q;
        retired_d = retired_q;

        if (accept) begin
            instr_d  = instr;
            // Read addresses are set up at accept, so they are stable through
            // DECODE and EXECUTE.
            raddr1_d = instr[7:4];
            raddr2_d = instr[3:0];
        end

        if (state_q == S_DECODE) begin
            case (op)
                OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_LDI, OP_MOV, OP_HALT: ;
                default: illegal_d = 1'b1;
            endcase
        end

        if (state_q == S_EXECUTE) begin
            waddr_d = dst;
            case (op)
                OP_ADD: begin
                    result_d = sum[DATA_W-1:0];
                    carry_d  = sum[DATA_W];
                end
                OP_SUB: begin
                    result_d = diff;
                    carry_d  = borrow;
                end
                OP_AND:  result_d = rf_data1 & rf_data2;
                OP_OR:   result_d = rf_data1 | rf_data2;
                OP_LDI:  result_d = {{(DATA_W-8){1'b0}}, instr_q[7:0]};
                OP_MOV:  result_d = rf_data1;
                default: result_d = result_q;
            endcase
            zero_d = (result_d == '0);
        end

        if (retire) begin
            retired_d = retired_q + CNT_W'(1);
        end
    end

    // State and datapath registers. Reset abandons any in-flight write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            instr_q   <= '0;
            raddr1_q  <= '0;
            raddr2_q  <= '0;
            waddr_q   <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            carry_q   <= 1'b0;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            raddr1_q  <= raddr1_d;
            raddr2_q  <= raddr2_d;
            waddr_q   <= waddr_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            carry_q   <= carry_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
        end
    end

    assign rf_addr_r1 = raddr1_q;
    assign rf_addr_r2 = raddr2_q;
    assign rf_addr_w  = waddr_q;
    assign rf_wdata   = result_q;
    assign flag_zero  = zero_q;
    assign flag_carry = carry_q;
    assign illegal    = illegal_q;
    assign retired    = retired_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_cpu_control.sv
// Directed testbench for cpu_control with a behavioural 16 x 16 register file.
module tb_cpu_control;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] instr = '0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [3:0]  rf_addr_r1, rf_addr_r2, rf_addr_w;
    logic [15:0] rf_data1, rf_data2, rf_wdata;
    logic        rf_we, flag_zero, flag_carry, illegal, halted;
    logic [15:0] retired;
    logic [2:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] rf_mem [16];
    int we_count  = 0;
    int we_double = 0;
    logic prev_we = 1'b0;

    // Clock and reset block.
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Register file: asynchronous reads and a synchronous write.
    assign rf_data1 = rf_mem[rf_addr_r1];
    assign rf_data2 = rf_mem[rf_addr_r2];
    always @(posedge clk) begin
        if (rf_we) rf_mem[rf_addr_w] <= rf_wdata;
    end

    // Write-pulse monitor.
    always @(posedge clk) begin
        if (rf_we) we_count <= we_count + 1;
        if (rf_we && prev_we) we_double <= we_double + 1;
        prev_we <= rf_we;
    end

    cpu_control #(.DATA_W(16), .CNT_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .rf_addr_r1  (rf_addr_r1),
        .rf_addr_r2  (rf_addr_r2),
        .rf_data1    (rf_data1),
        .rf_data2    (rf_data2),
        .rf_addr_w   (rf_addr_w),
        .rf_we       (rf_we),
        .rf_wdata    (rf_wdata),
        .flag_zero   (flag_zero),
        .flag_carry  (flag_carry),
        .illegal     (illegal),
        .halted      (halted),
        .retired     (retired),
        .dbg_state   (dbg_state)
    );

    // Driver: wait for ready, present one instruction for one edge.
    // Returns at the falling edge after the accept.
    task automatic issue(input logic [15:0] w);
        int t = 0;
        while (instr_ready !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (instr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL issue_ready_timeout: instr_ready=%b required 1", instr_ready);
        end else begin
            instr = w;
            instr_valid = 1'b1;
            @(posedge clk);
            #1 instr_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    // Driver: wait for the controller to return to IDLE or reach HALTED.
    task automatic wait_done();
        int t = 0;
        while (instr_ready !== 1'b1 && halted !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (instr_ready !== 1'b1 && halted !== 1'b1) begin
            n_fail++;
            $display("FAIL done_timeout: ready=%b halted=%b required one of them 1", instr_ready, halted);
        end
    endtask

    task automatic run(input logic [15:0] w);
        issue(w);
        wait_done();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b required 1", instr_ready); end
        n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b required 0", rf_we); end
        n_checks++; if (halted !== 1'b0 || illegal !== 1'b0) begin n_fail++; $display("FAIL reset_status: halted=%b illegal=%b required 0 0", halted, illegal); end
        n_checks++; if (flag_zero !== 1'b0 || flag_carry !== 1'b0) begin n_fail++; $display("FAIL reset_flags: z=%b c=%b required 0 0", flag_zero, flag_carry); end
        n_checks++; if (retired !== 16'h0000) begin n_fail++; $display("FAIL reset_retired: got %h required 0000", retired); end
        n_checks++; if (rf_wdata !== 16'h0000 || rf_addr_w !== 4'h0) begin n_fail++; $display("FAIL reset_wport: addr=%h data=%h required 0 0000", rf_addr_w, rf_wdata); end
        n_checks++; if (rf_addr_r1 !== 4'h0 || rf_addr_r2 !== 4'h0) begin n_fail++; $display("FAIL reset_raddr: r1=%h r2=%h required 0 0", rf_addr_r1, rf_addr_r2); end
        n_checks++; if (dbg_state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d required 0", dbg_state); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_latency();
        int we0 = we_count;
        // LDI r1,0x05 with an explicit per-cycle look at the write strobe.
        issue(16'h5105);
        n_checks++; if (rf_we !== 1'b0 || instr_ready !== 1'b0) begin n_fail++; $display("FAIL lat_k0: we=%b ready=%b required 0 0", rf_we, instr_ready); end
        @(negedge clk);
        n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL lat_k1: we=%b required 0", rf_we); end
        @(negedge clk);
        n_checks++; if (rf_we !== 1'b1 || rf_addr_w !== 4'h1 || rf_wdata !== 16'h0005) begin n_fail++; $display("FAIL lat_k2: we=%b addr=%h data=%h required 1 1 0005", rf_we, rf_addr_w, rf_wdata); end
        @(negedge clk);
        n_checks++; if (rf_we !== 1'b0 || instr_ready !== 1'b1) begin n_fail++; $display("FAIL lat_k3: we=%b ready=%b required 0 1", rf_we, instr_ready); end
        n_checks++; if (rf_mem[1] !== 16'h0005 || we_count - we0 !== 1) begin n_fail++; $display("FAIL lat_write: r1=%h pulses=%0d required 0005 1", rf_mem[1], we_count - we0); end
    endtask

    task automatic test_basic();
        int we0 = we_count;
        run(16'h5203);           // LDI r2,0x03
        run(16'h1312);           // ADD r3,r1,r2
        n_checks++; if (rf_mem[3] !== 16'h0008) begin n_fail++; $display("FAIL basic_r3: got %h required 0008", rf_mem[3]); end
        n_checks++; if (flag_zero !== 1'b0 || flag_carry !== 1'b0) begin n_fail++; $display("FAIL basic_flags: z=%b c=%b required 0 0", flag_zero, flag_carry); end
        n_checks++; if (retired !== 16'd3) begin n_fail++; $display("FAIL basic_retired: got %0d required 3", retired); end
        n_checks++; if (we_count - we0 !== 2 || we_double !== 0) begin n_fail++; $display("FAIL basic_pulses: pulses=%0d doubles=%0d required 2 0", we_count - we0, we_double); end
        n_checks++; if (rf_wdata !== 16'h0008 || rf_addr_w !== 4'h3) begin n_fail++; $display("FAIL basic_hold: addr=%h data=%h required 3 0008", rf_addr_w, rf_wdata); end
    endtask

    task automatic test_alu_flags();
        run(16'h5601);           // LDI r6,0x01
        run(16'h2106);           // SUB r1,r0,r6 -> FFFF with borrow
        n_checks++; if (rf_mem[1] !== 16'hFFFF || flag_carry !== 1'b1 || flag_zero !== 1'b0) begin n_fail++; $display("FAIL sub_borrow: r1=%h c=%b z=%b required FFFF 1 0", rf_mem[1], flag_carry, flag_zero); end
        run(16'h1411);           // ADD r4,r1,r1
        n_checks++; if (rf_mem[4] !== 16'hFFFE || flag_carry !== 1'b1 || flag_zero !== 1'b0) begin n_fail++; $display("FAIL add_carry: r4=%h c=%b z=%b required FFFE 1 0", rf_mem[4], flag_carry, flag_zero); end
        run(16'h3712);           // AND r7,r1,r2 -> 0003, carry held
        n_checks++; if (rf_mem[7] !== 16'h0003 || flag_carry !== 1'b1) begin n_fail++; $display("FAIL and_hold: r7=%h c=%b required 0003 1", rf_mem[7], flag_carry); end
        run(16'h2522);           // SUB r5,r2,r2 -> 0
        n_checks++; if (rf_mem[5] !== 16'h0000 || flag_zero !== 1'b1 || flag_carry !== 1'b0) begin n_fail++; $display("FAIL sub_zero: r5=%h z=%b c=%b required 0000 1 0", rf_mem[5], flag_zero, flag_carry); end
        run(16'h4832);           // OR r8,r3,r2 -> 000B
        n_checks++; if (rf_mem[8] !== 16'h000B || flag_zero !== 1'b0) begin n_fail++; $display("FAIL or: r8=%h z=%b required 000B 0", rf_mem[8], flag_zero); end
        run(16'h6930);           // MOV r9,r3 -> 0008
        n_checks++; if (rf_mem[9] !== 16'h0008) begin n_fail++; $display("FAIL mov: r9=%h required 0008", rf_mem[9]); end
        run(16'h5A00);           // LDI r10,0x00 -> zero flag
        n_checks++; if (rf_mem[10] !== 16'h0000 || flag_zero !== 1'b1 || flag_carry !== 1'b0) begin n_fail++; $display("FAIL ldi_zero: r10=%h z=%b c=%b required 0000 1 0", rf_mem[10], flag_zero, flag_carry); end
        n_checks++; if (retired !== 16'd11) begin n_fail++; $display("FAIL alu_retired: got %0d required 11", retired); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] prog [5];
        int idx = 0, cyc = 0, last_rdy = -1, rdy_cnt = 0, gap_bad = 0;
        int we0 = we_count;
        logic [15:0] ret0 = retired;
        prog[0] = 16'h5C11;      // LDI r12,0x11
        prog[1] = 16'h5D22;      // LDI r13,0x22
        prog[2] = 16'h5E33;      // LDI r14,0x33
        prog[3] = 16'h5F44;      // LDI r15,0x44
        prog[4] = 16'h1BCD;      // ADD r11,r12,r13 -> 0x33
        instr = prog[0];
        while (idx < 5 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            instr_valid = 1'b1;
            if (instr_ready === 1'b1) begin
                if (last_rdy >= 0 && cyc - last_rdy != 4) gap_bad++;
                last_rdy = cyc;
                rdy_cnt++;
                @(posedge clk);
                idx++;
                #1;
                if (idx < 5) instr = prog[idx];
                else instr_valid = 1'b0;
            end
        end
        instr_valid = 1'b0;
        @(negedge clk);
        wait_done();
        n_checks++; if (rdy_cnt !== 5 || gap_bad !== 0) begin n_fail++; $display("FAIL b2b_ready: ready_cycles=%0d bad_gaps=%0d required 5 0", rdy_cnt, gap_bad); end
        n_checks++; if (we_count - we0 !== 5 || we_double !== 0) begin n_fail++; $display("FAIL b2b_pulses: pulses=%0d doubles=%0d required 5 0", we_count - we0, we_double); end
        n_checks++; if (retired - ret0 !== 16'd5) begin n_fail++; $display("FAIL b2b_retired: delta=%0d required 5", retired - ret0); end
        n_checks++; if (rf_mem[12] !== 16'h0011 || rf_mem[13] !== 16'h0022 || rf_mem[14] !== 16'h0033 || rf_mem[15] !== 16'h0044) begin n_fail++; $display("FAIL b2b_regs: r12..r15=%h %h %h %h required 0011 0022 0033 0044", rf_mem[12], rf_mem[13], rf_mem[14], rf_mem[15]); end
        n_checks++; if (rf_mem[11] !== 16'h0033) begin n_fail++; $display("FAIL b2b_hazard: r11=%h required 0033", rf_mem[11]); end
    endtask

    task automatic test_illegal();
        int we0 = we_count;
        logic [15:0] ret0 = retired;
        run(16'h9123);           // opcode 9 is undefined
        n_checks++; if (illegal !== 1'b1) begin n_fail++; $display("FAIL illegal_set: got %b required 1", illegal); end
        n_checks++; if (we_count - we0 !== 0 || retired !== ret0 || rf_mem[1] !== 16'hFFFF) begin n_fail++; $display("FAIL illegal_effect: pulses=%0d retired=%0d r1=%h required 0 %0d FFFF", we_count - we0, retired, rf_mem[1], ret0); end
        run(16'h5142);           // LDI r1,0x42
        n_checks++; if (rf_mem[1] !== 16'h0042 || illegal !== 1'b1 || retired !== ret0 + 16'd1) begin n_fail++; $display("FAIL illegal_after: r1=%h illegal=%b retired=%0d required 0042 1 %0d", rf_mem[1], illegal, retired, ret0 + 16'd1); end
        run(16'h0000);           // NOP
        n_checks++; if (retired !== ret0 + 16'd2 || we_count - we0 !== 1) begin n_fail++; $display("FAIL nop: retired=%0d pulses=%0d required %0d 1", retired, we_count - we0, ret0 + 16'd2); end
    endtask

    task automatic test_halt();
        int we0 = we_count, rdy_seen = 0;
        logic [15:0] ret0 = retired;
        run(16'hF000);           // HALT
        n_checks++; if (halted !== 1'b1 || instr_ready !== 1'b0 || retired !== ret0 + 16'd1) begin n_fail++; $display("FAIL halt_enter: halted=%b ready=%b retired=%0d required 1 0 %0d", halted, instr_ready, retired, ret0 + 16'd1); end
        instr = 16'h5299;        // LDI r2,0x99 must be ignored
        instr_valid = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (instr_ready !== 1'b0 || halted !== 1'b1) rdy_seen++;
        end
        instr_valid = 1'b0;
        n_checks++; if (rdy_seen !== 0 || we_count - we0 !== 0 || rf_mem[2] !== 16'h0003) begin n_fail++; $display("FAIL halt_stay: bad_cycles=%0d pulses=%0d r2=%h required 0 0 0003", rdy_seen, we_count - we0, rf_mem[2]); end
        reset = 1'b1;
        #1;
        n_checks++; if (halted !== 1'b0 || instr_ready !== 1'b1 || illegal !== 1'b0 || retired !== 16'd0) begin n_fail++; $display("FAIL halt_reset: halted=%b ready=%b illegal=%b retired=%0d required 0 1 0 0", halted, instr_ready, illegal, retired); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        issue(16'h5377);         // LDI r3,0x77, r3 currently 0008
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (rf_we !== 1'b1 || dbg_state !== 3'd3) begin n_fail++; $display("FAIL mid_wb: we=%b state=%0d required 1 3", rf_we, dbg_state); end
        reset = 1'b1;
        #1;
        n_checks++; if (rf_we !== 1'b0 || instr_ready !== 1'b1 || dbg_state !== 3'd0) begin n_fail++; $display("FAIL mid_async: we=%b ready=%b state=%0d required 0 1 0", rf_we, instr_ready, dbg_state); end
        n_checks++; if (rf_wdata !== 16'h0000 || rf_addr_w !== 4'h0 || flag_zero !== 1'b0 || flag_carry !== 1'b0 || retired !== 16'd0) begin n_fail++; $display("FAIL mid_outputs: data=%h addr=%h z=%b c=%b retired=%0d required 0000 0 0 0 0", rf_wdata, rf_addr_w, flag_zero, flag_carry, retired); end
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (rf_mem[3] !== 16'h0008) begin n_fail++; $display("FAIL mid_r3: got %h required 0008", rf_mem[3]); end
        reset = 1'b0;
        @(negedge clk);
        run(16'h5455);           // LDI r4,0x55 after recovery
        n_checks++; if (rf_mem[4] !== 16'h0055 || retired !== 16'd1) begin n_fail++; $display("FAIL mid_recover: r4=%h retired=%0d required 0055 1", rf_mem[4], retired); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rf_mem[i] = 16'h0000;
        test_reset();
        test_latency();
        test_basic();
        test_alu_flags();
        test_back_to_back();
        test_illegal();
        test_halt();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_control.md
Name: cpu_control

Overview:
- Multicycle control unit and ALU sequencer for the 16-entry x 16-bit register file (2 async read ports, 1 sync write port).
- Accepts one 16-bit instruction per valid/ready handshake, reads sources, computes the result, and writes it back through the file's single write port.
- Sits between the instruction source and the register file; the only agent driving register-file addresses and write enable.

Parameters:
- DATA_W, 16, register/ALU datapath width
- CNT_W, 16, width of retired-instruction counter

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- instr  input  16  instruction word: [15:12] op, [11:8] dst, [7:4] src1, [3:0] src2
- instr_valid  input  1  instr is valid
- instr_ready  output  1  controller can accept instr
- rf_addr_r1  output  4  register-file read address 1
- rf_addr_r2  output  4  register-file read address 2
- rf_data1  input  DATA_W  register-file read data 1 (combinational from rf_addr_r1)
- rf_data2  input  DATA_W  register-file read data 2
- rf_addr_w  output  4  register-file write address
- rf_we  output  1  register-file write enable
- rf_wdata  output  DATA_W  register-file write data
- flag_zero  output  1  last ALU result was zero
- flag_carry  output  1  carry/borrow of last ADD/SUB
- illegal  output  1  sticky: undefined opcode seen
- halted  output  1  HALT executed
- retired  output  CNT_W  count of instructions completed

Behaviour:
- Reset (async, immediate): state=IDLE; instr_ready=1; all other outputs 0; instr register=0.
- Opcodes:
  - 0 NOP
  - 1 ADD: dst=s1+s2; carry=carry-out
  - 2 SUB: dst=s1-s2; carry=1 on borrow (s1<s2 unsigned)
  - 3 AND
  - 4 OR
  - 5 LDI: dst=zero-extend instr[7:0]; no reads used
  - 6 MOV: dst=s1
  - F HALT
  - 7-E illegal
- FSM states: IDLE, DECODE, EXECUTE, WRITEBACK, HALTED.
- IDLE:
  - instr_ready=1.
  - On instr_valid at an edge: latch instr, go DECODE. Accept occurs only when instr_valid and instr_ready are both high.
- DECODE:
  - instr_ready=0.
  - rf_addr_r1=src1, rf_addr_r2=src2, registered, held through EXECUTE.
  - HALT: go HALTED, retired+1.
  - Illegal: set illegal, go IDLE, no write, retired unchanged.
  - NOP: retired+1, go IDLE.
  - Else: go EXECUTE.
- EXECUTE:
  - Compute the DATA_W-bit result (modulo 2^DATA_W) from rf_data1/rf_data2 into the result register.
  - Update flag_zero; update flag_carry on ADD/SUB only, otherwise hold it. LDI and MOV also update flag_zero.
  - Go WRITEBACK.
- WRITEBACK:
  - rf_we=1 for exactly one cycle; rf_addr_w=dst; rf_wdata=result.
  - retired+1; go IDLE.
  - rf_we=0 in all other states; rf_addr_w and rf_wdata hold their last value.
- HALTED:
  - halted=1, instr_ready=0.
  - Remains here until reset; instr_valid is ignored.
- Latency: accept at edge k, rf_we high during cycle after edge k+2, register written at edge k+3, instr_ready high again after edge k+3. ALU-op throughput is 1 instruction / 4 cycles.
- Hazards: a read of a register written by the previous instruction sees the new value, because the write completes before the next DECODE. No forwarding is required.
- src1==src2 or dst==src: legal, normal results.
- retired wraps from 2^CNT_W-1 to 0.
- illegal clears only on reset.
- Reset mid-operation (any state): the pending write is abandoned; rf_we drops immediately.

Test Plan:
- LDI r1,0x05; LDI r2,0x03; ADD r3,r1,r2 -> r3=0x0008, flag_zero=0, flag_carry=0, retired=3, rf_we pulses exactly 3 single cycles.
- LDI r1,0xFF (then r1 chained to 0xFFFF via ADD loop setup) ADD r4,r1,r1 with r1=0xFFFF -> r4=0xFFFE, carry=1; SUB r5,r2,r2 -> r5=0, zero=1, carry=0.
- Handshake timing: instr_valid held high continuously -> instr_ready high 1 cycle of every 4, exactly one accept per ready cycle, no instruction duplicated or dropped.
- Opcode 0x9 -> illegal=1, no rf_we, retired unchanged; next LDI executes normally and illegal stays 1.
- HALT then further valid instrs -> halted=1, instr_ready=0 permanently, no rf_we; reset -> halted=0, instr_ready=1.
- Assert reset during WRITEBACK -> rf_we=0 immediately (asynchronous), destination register unchanged, all outputs at reset values.
